// File: rtl/fir_mac_ctrl.sv
// rtl/fir_mac_ctrl.sv - FIR tap sequencer and MAC adder feeding acc_module
// Optional FIR_SAT_EN: clamp suma_wynik on signed overflow instead of wrapping.
module fir_mac_ctrl #(
    parameter int N_TAPS = 16,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic                       clk_b,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic signed [ACC_W-1:0]    Acc_out,
    output logic signed [ACC_W-1:0]    suma_wynik,
    output logic                       FSM_reset_Acc,
    output logic                       FSM_Acc_en,
    output logic                       FSM_Acc_zapis,
    output logic                       wynik_valid
);

    localparam int AW = $clog2(N_TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);
    localparam logic [AW-1:0] N_MOD  = AW'(N_TAPS);
    localparam logic [AW:0]   N_EXT  = (AW + 1)'(N_TAPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_SAVE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] newest_q, newest_d;

    logic signed [DATA_W-1:0] x_q [N_TAPS];
    logic signed [COEF_W-1:0] h_q [N_TAPS];

    logic                     accept;
    logic                     coef_wr;
    logic [AW-1:0]            rd_idx;
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum_raw;

    assign accept  = (state_q == S_IDLE) && sample_valid;
    assign coef_wr = (state_q == S_IDLE) && coef_we && ({1'b0, coef_addr} < N_EXT);

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_CLR;
            S_CLR:   state_d = S_MAC;
            S_MAC:   if (k_q == K_LAST) state_d = S_SAVE;
            S_SAVE:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sample_ready  = 1'b0;
        FSM_reset_Acc = 1'b0;
        FSM_Acc_en    = 1'b0;
        FSM_Acc_zapis = 1'b0;
        wynik_valid   = 1'b0;
        case (state_q)
            S_IDLE:  sample_ready  = 1'b1;
            S_CLR:   FSM_reset_Acc = 1'b1;
            S_MAC:   FSM_Acc_en    = 1'b1;
            S_SAVE:  FSM_Acc_zapis = 1'b1;
            S_DONE:  wynik_valid   = 1'b1;
            default: sample_ready  = 1'b0;
        endcase
    end

    // newest_q remembers the slot just written so tap k=0 always reads it
    always_comb begin
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        newest_d = newest_q;
        if (accept) begin
            k_d      = '0;
            newest_d = wr_ptr_q;
            wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
        end else if (state_q == S_MAC) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            wr_ptr_q <= '0;
            newest_q <= '0;
        end else begin
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
            newest_q <= newest_d;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            if (coef_wr) begin
                h_q[coef_addr] <= coef_data;
            end
            if (accept) begin
                x_q[wr_ptr_q] <= sample_in;
            end
        end
    end

    // (newest - k) mod N; the true result is below N so AW-bit wrap is exact
    always_comb begin
        if (newest_q >= k_q) begin
            rd_idx = newest_q - k_q;
        end else begin
            rd_idx = newest_q + N_MOD - k_q;
        end
    end

    assign x_sel    = x_q[rd_idx];
    assign c_sel    = h_q[k_q];
    assign prod     = $signed({{COEF_W{x_sel[DATA_W-1]}}, x_sel})
                    * $signed({{DATA_W{c_sel[COEF_W-1]}}, c_sel});
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign sum_raw  = Acc_out + prod_ext;

`ifdef FIR_SAT_EN
    always_comb begin
        suma_wynik = sum_raw;
        if (!Acc_out[ACC_W-1] && !prod_ext[ACC_W-1] && sum_raw[ACC_W-1]) begin
            suma_wynik = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (Acc_out[ACC_W-1] && prod_ext[ACC_W-1] && !sum_raw[ACC_W-1]) begin
            suma_wynik = {1'b1, {(ACC_W-1){1'b0}}};
        end
    end
`else
    assign suma_wynik = sum_raw;
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb/tb_fir_mac_ctrl.sv - scoreboard bench for fir_mac_ctrl with behavioural accumulators
module tb_fir_mac_ctrl;

    logic               clk_b = 1'b0;
    logic               rst_n;
    logic signed [7:0]  sample_in;
    logic               sample_valid;
    logic               sample_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic signed [20:0] acc_q;
    logic signed [20:0] suma;
    logic signed [20:0] probka;
    logic               rst_acc, acc_en, zapis, wynik_valid;

    logic signed [7:0]  s64_in;
    logic               s64_valid, s64_ready;
    logic               c64_we;
    logic [5:0]         c64_addr;
    logic signed [7:0]  c64_data;
    logic signed [20:0] acc64_q, suma64, probka64;
    logic               r64, e64, z64, v64;

    int     checks = 0;
    int     errors = 0;
    int     hist[$];
    int     h[16];
    longint exp_q[$];
    int     age = -1;

    always #5 clk_b = ~clk_b;

    fir_mac_ctrl #(.N_TAPS(16), .DATA_W(8), .COEF_W(8), .ACC_W(21)) dut (
        .clk_b(clk_b), .rst_n(rst_n),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .Acc_out(acc_q), .suma_wynik(suma),
        .FSM_reset_Acc(rst_acc), .FSM_Acc_en(acc_en), .FSM_Acc_zapis(zapis),
        .wynik_valid(wynik_valid)
    );

    fir_mac_ctrl #(.N_TAPS(64), .DATA_W(8), .COEF_W(8), .ACC_W(21)) dut64 (
        .clk_b(clk_b), .rst_n(rst_n),
        .sample_in(s64_in), .sample_valid(s64_valid), .sample_ready(s64_ready),
        .coef_we(c64_we), .coef_addr(c64_addr), .coef_data(c64_data),
        .Acc_out(acc64_q), .suma_wynik(suma64),
        .FSM_reset_Acc(r64), .FSM_Acc_en(e64), .FSM_Acc_zapis(z64),
        .wynik_valid(v64)
    );

    // acc_module stand-ins: clear, load, and copy-out registers
    always @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            probka <= '0;
        end else begin
            if (rst_acc) acc_q <= '0;
            else if (acc_en) acc_q <= suma;
            if (zapis) probka <= acc_q;
        end
    end

    always @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            acc64_q  <= '0;
            probka64 <= '0;
        end else begin
            if (r64) acc64_q <= '0;
            else if (e64) acc64_q <= suma64;
            if (z64) probka64 <= acc64_q;
        end
    end

    function automatic void check(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, want, want, $time);
        end
    endfunction

    function automatic longint fold(longint v);
        longint lim;
        longint m;
        lim = longint'(1) <<< 20;
        m   = v;
`ifdef FIR_SAT_EN
        if (v > lim - 1) m = lim - 1;
        else if (v < -lim) m = -lim;
`else
        m = v & ((lim <<< 1) - 1);
        if (m >= lim) m = m - (lim <<< 1);
`endif
        return m;
    endfunction

    // y[n] = sum_k h[k]*x[n-k], accumulated tap by tap in ACC_W-bit arithmetic
    function automatic longint model16();
        longint acc;
        longint xs;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            xs  = (k < hist.size()) ? longint'(hist[k]) : 0;
            acc = fold(acc + longint'(h[k]) * xs);
        end
        return acc;
    endfunction

    task automatic cycle();
        @(posedge clk_b);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!sample_ready && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: sample_ready still 0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic write_coef(int a, int d);
        wait_ready();
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 8'(d);
        h[a]      = d;
        cycle();
        coef_we   = 1'b0;
    endtask

    task automatic busy_write(int a, int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 8'(d);
        cycle();
        coef_we   = 1'b0;
    endtask

    task automatic send(int x, bit w, int a, int d);
        wait_ready();
        if (w) begin
            coef_we   = 1'b1;
            coef_addr = 4'(a);
            coef_data = 8'(d);
            h[a]      = d;
        end
        sample_in    = 8'(x);
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        hist.push_front(x);
        exp_q.push_back(model16());
    endtask

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Timeline expected after a handshake at T: CLR, 16x MAC, SAVE, DONE
    always @(negedge clk_b) begin
        logic [4:0] want;
        if (!rst_n) begin
            age = -1;
        end else begin
            want = {age < 1, age == 1, age >= 2 && age <= 17, age == 18, age == 19};
            check("timing{rdy,clr,en,zapis,valid}",
                  {sample_ready, rst_acc, acc_en, zapis, wynik_valid}, want);
            if (age >= 1 && age < 19) age = age + 1;
            else if (age == 19) age = -1;
            else if (sample_valid) age = 1;
        end
    end

    always @(negedge clk_b) begin
        if (rst_n && wynik_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: wynik_valid with %0d, none required", probka);
            end else begin
                check("result", probka, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        sample_in = '0; sample_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        s64_in = '0; s64_valid = 1'b0; c64_we = 1'b0; c64_addr = '0; c64_data = '0;
        for (int k = 0; k < 16; k++) h[k] = 0;
        repeat (3) @(posedge clk_b);
        #1;
        check("reset_ready", sample_ready, 1);
        check("reset_ctrl", {rst_acc, acc_en, zapis, wynik_valid}, 0);
        check("reset_probka", probka, 0);
        rst_n = 1'b1;
        cycle();

        for (int k = 0; k < 16; k++) write_coef(k, k + 1);
        send(1, 1'b0, 0, 0);
        repeat (17) send(0, 1'b0, 0, 0);

        for (int k = 0; k < 16; k++) write_coef(k, -128);
        repeat (16) send(-128, 1'b0, 0, 0);

        for (int k = 0; k < 16; k++) write_coef(k, rnd8());
        send(rnd8(), 1'b0, 0, 0);
        repeat (4) cycle();
        busy_write(3, 99);
        busy_write(0, -77);
        send(rnd8(), 1'b0, 0, 0);
        send(rnd8(), 1'b1, 2, 55);
        send(rnd8(), 1'b1, 0, -1);

        repeat (30) begin
            if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, 15)), rnd8());
            send(rnd8(), $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), rnd8());
        end

        send(rnd8(), 1'b0, 0, 0);
        repeat (6) cycle();
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        hist.delete();
        for (int k = 0; k < 16; k++) h[k] = 0;
        cycle();
        check("midrst_ready", sample_ready, 1);
        check("midrst_ctrl", {rst_acc, acc_en, zapis, wynik_valid}, 0);
        rst_n = 1'b1;
        cycle();
        for (int k = 0; k < 16; k++) write_coef(k, (k == 0) ? 5 : rnd8());
        send(3, 1'b0, 0, 0);
        send(-2, 1'b0, 0, 0);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        for (int i = 0; i < 64; i++) begin
            c64_we = 1'b1; c64_addr = 6'(i); c64_data = -8'sd128;
            cycle();
        end
        c64_we = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            s64_in = -8'sd128;
            n = 0;
            while (!s64_ready && n < 100) begin cycle(); n++; end
            s64_valid = 1'b1;
            cycle();
            s64_valid = 1'b0;
            n = 0;
            while (!v64 && n < 100) begin cycle(); n++; end
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL tap64_timeout: no wynik_valid for sample %0d, required within 100 cycles", i);
            end else begin
                check("tap64_result", probka64, fold(longint'(i) * 16384));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
